// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared states, default parameters and sizing helper for the clock monitor
package clock_monitor_pkg;
  localparam int NOM_HALF_DEF = 100;
  localparam int TOL_DEF = 2;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_e;
  function automatic int gc_width(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction
endpackage

// File: rtl/clock_monitor_if.sv
// clock_monitor_if: monitored clock input, fault clear and status outputs of the clock monitor
interface clock_monitor_if
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic clk_mon;
  logic fault_clr;
  logic rise_tick;
  logic fall_tick;
  logic [CNT_W-1:0] half_period;
  logic locked;
  logic fault;
  modport master (
    output clk_mon, fault_clr,
    input  rise_tick, fall_tick, half_period, locked, fault
  );
  modport slave (
    input  clk_mon, fault_clr,
    output rise_tick, fall_tick, half_period, locked, fault
  );
endinterface

// File: rtl/clock_monitor_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus history flop, giving raw and registered edge pulses
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic rise_tick,
  output logic fall_tick
);
  logic s1_q, s2_q, s3_q, rise_tick_q, fall_tick_q;
  logic s1_d, s2_d, s3_d, rise_tick_d, fall_tick_d;
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    rise_tick_d = rise;
    fall_tick_d = fall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
    end
  end
  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures half-periods of a divided clock sampled in clk_in and tracks lock/fault status
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int NOM_HALF = NOM_HALF_DEF,
  parameter int TOL = TOL_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk_in,
  input logic rst,
  clock_monitor_if.slave mon
);
  localparam int GC_W = gc_width(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LO = CNT_W'(NOM_HALF - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(NOM_HALF + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(NOM_HALF + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_COUNT);
  logic rise, fall, edge_det, good, set_fault;
  logic [GC_W-1:0] gc_inc;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, half_period_q, half_period_d;
  logic [GC_W-1:0] gc_q, gc_d;
  logic fault_q, fault_d;
  sync_edge_detect u_sync (
    .clk(clk_in),
    .rst(rst),
    .d(mon.clk_mon),
    .rise(rise),
    .fall(fall),
    .rise_tick(mon.rise_tick),
    .fall_tick(mon.fall_tick)
  );
  always_comb begin
    edge_det = rise | fall;
    good = (cnt_q >= LO) && (cnt_q <= HI);
    gc_inc = gc_q + 1'b1;
    cnt_d = edge_det ? CNT_W'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
    half_period_d = edge_det ? cnt_q : half_period_q;
    state_d = state_q;
    gc_d = gc_q;
    set_fault = 1'b0;
    case (state_q)
      IDLE, LOST: begin
        if (edge_det) begin
          state_d = ACQ;
          gc_d = '0;
        end
      end
      ACQ: begin
        if (edge_det) begin
          gc_d = good ? gc_inc : '0;
          state_d = (good && gc_inc == GC_LOCK) ? LOCKED : ACQ;
        end
      end
      LOCKED: begin
        // a stopped clock never produces an edge, so the counter itself flags the loss
        if (edge_det ? !good : cnt_q == TIMEOUT) begin
          state_d = LOST;
          set_fault = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fault_d = set_fault | (fault_q & ~mon.fault_clr);
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      half_period_q <= '0;
      gc_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      half_period_q <= half_period_d;
      gc_q <= gc_d;
      fault_q <= fault_d;
    end
  end
  assign mon.half_period = half_period_q;
  assign mon.locked = (state_q == LOCKED);
  assign mon.fault = fault_q;
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed checks of lock, tolerance, stall timeout, fault clear and reset behaviour
module tb_clock_monitor;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic o_rise, o_fall, o_locked, o_fault;
  logic [7:0] o_hp;
  clock_monitor_if #(.CNT_W(8)) mon ();
  clock_monitor dut (
    .clk_in(clk_in),
    .rst(rst),
    .mon(mon)
  );
  always #5 clk_in = ~clk_in;
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rise_tick"}, mon.rise_tick, 0);
    chk({tag, "_fall_tick"}, mon.fall_tick, 0);
    chk({tag, "_half_period"}, mon.half_period, 0);
    chk({tag, "_locked"}, mon.locked, 0);
    chk({tag, "_fault"}, mon.fault, 0);
  endtask
  // toggle clk_mon, capture status in the tick cycle, then hold for the rest of n cycles
  task automatic hp(input int n);
    mon.clk_mon = ~mon.clk_mon;
    step(3);
    o_rise = mon.rise_tick;
    o_fall = mon.fall_tick;
    o_locked = mon.locked;
    o_fault = mon.fault;
    o_hp = mon.half_period;
    chk("rise_tick", o_rise, mon.clk_mon);
    chk("fall_tick", o_fall, !mon.clk_mon);
    step(1);
    chk("tick_width", mon.rise_tick | mon.fall_tick, 0);
    step(n - 4);
  endtask
  initial begin
    mon.clk_mon = 1'b0;
    mon.fault_clr = 1'b0;
    step(2);
    chk_zero_outputs("reset");
    rst = 1'b0;
    repeat (4) hp(100);
    chk("nominal_locked_edge4", o_locked, 0);
    hp(100);
    chk("nominal_locked_edge5", o_locked, 1);
    chk("nominal_half_period", o_hp, 100);
    chk("nominal_fault", o_fault, 0);
    step(5);
    chk("stall_locked_at_102", mon.locked, 1);
    chk("stall_fault_at_102", mon.fault, 0);
    step(1);
    chk("stall_locked_at_103", mon.locked, 0);
    chk("stall_fault_at_103", mon.fault, 1);
    step(200);
    hp(100);
    chk("resume_saturated_half_period", o_hp, 255);
    chk("resume_locked_edge1", o_locked, 0);
    repeat (3) hp(100);
    chk("resume_locked_edge4", o_locked, 0);
    hp(50);
    chk("resume_locked_edge5", o_locked, 1);
    chk("resume_fault_sticky", o_fault, 1);
    mon.clk_mon = ~mon.clk_mon;
    step(2);
    mon.fault_clr = 1'b1;
    step(1);
    mon.fault_clr = 1'b0;
    chk("collision_tick", mon.rise_tick | mon.fall_tick, 1);
    chk("collision_locked", mon.locked, 0);
    chk("collision_fault", mon.fault, 1);
    step(5);
    mon.fault_clr = 1'b1;
    step(1);
    mon.fault_clr = 1'b0;
    chk("lone_clear_fault", mon.fault, 0);
    repeat (4) hp(100);
    chk("relock_locked_edge4", o_locked, 0);
    hp(100);
    chk("relock_locked_edge5", o_locked, 1);
    chk("relock_fault", o_fault, 0);
    rst = 1'b1;
    step(1);
    chk_zero_outputs("midlock_reset");
    rst = 1'b0;
    repeat (4) hp(100);
    chk("post_reset_locked_edge4", o_locked, 0);
    hp(100);
    chk("post_reset_locked_edge5", o_locked, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    chk("release_high_rise_tick", mon.rise_tick, 1);
    repeat (5) hp(103);
    chk("oot_locked", o_locked, 0);
    chk("oot_half_period", o_hp, 103);
    chk("oot_fault", o_fault, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    hp(98);
    hp(102);
    hp(98);
    hp(102);
    chk("bounds_locked_edge4", o_locked, 0);
    hp(98);
    chk("bounds_locked_edge5", o_locked, 1);
    chk("bounds_half_period", o_hp, 102);
    chk("bounds_fault", o_fault, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_monitor.md
# clock_monitor

Supervises the slow clock produced by the on-chip clock divider, sampled as data in the fast `clk_in` domain. The block synchronizes the monitored clock, emits single-cycle edge ticks for fast-domain logic, measures every half-period in `clk_in` cycles, and reports lock and fault status against the nominal divide ratio. It sits beside the divider in the core's clock/reset area and feeds status to debug and reset logic.

## Interface
- `NOM_HALF`, 100: nominal half-period in `clk_in` cycles. The divider toggles every 100 cycles.
- `TOL`, 2: allowed deviation, in cycles, from `NOM_HALF`.
- `LOCK_COUNT`, 4: consecutive in-range measurements needed to lock.
- `CNT_W`, 8: width of the period counter and of `half_period`.
- `clk_in`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `clk_mon`, in, 1: monitored slow clock, treated as asynchronous data.
- `fault_clr`, in, 1: clears the sticky `fault` flag.
- `rise_tick`, out, 1: one-cycle pulse per detected rising edge.
- `fall_tick`, out, 1: one-cycle pulse per detected falling edge.
- `half_period`, out, `CNT_W`: last measured edge-to-edge interval.
- `locked`, out, 1: monitored clock is within tolerance.
- `fault`, out, 1: sticky; set when lock is lost.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`, followed by a history flop `s3`. All reset to 0.
- **Edge detection:**
  - A rise is `s2 & ~s3`; a fall is `~s2 & s3`.
  - Ticks are registered outputs.
  - An edge is either a rise or a fall.
- **Counter `cnt`:**
  - Loads 1 in the cycle after an edge; otherwise increments.
  - Saturates at 2^CNT_W−1.
  - On an edge, `half_period <= cnt`.
  - "Good" means NOM_HALF−TOL ≤ cnt ≤ NOM_HALF+TOL, evaluated on `cnt` at the edge.
- **FSM states and transitions:**
  - IDLE → ACQ on the first edge. No measurement is evaluated for this edge.
  - ACQ keeps a good-count `gc`:
    - A good edge increments `gc`.
    - A bad edge clears `gc`.
    - When `gc` reaches LOCK_COUNT, go to LOCKED.
    - Timeouts are ignored in ACQ.
  - LOCKED sets `locked=1`. A bad edge or a timeout (`cnt == NOM_HALF+TOL+1` with no edge) goes to LOST and sets `fault`.
  - LOST sets `locked=0`. The next edge goes to ACQ with `gc=0`; this edge is not evaluated.
- **`fault`:**
  - Sticky; cleared by `fault_clr`.
  - If a set and `fault_clr` occur in the same cycle, the set wins.
- **Reset values:** all outputs 0, `cnt=0`, `gc=0`, state IDLE.
  - Reset applies even mid-lock.
  - If `clk_mon` is high at reset release, the resulting rise counts as the IDLE first edge.

## Timing
- `clk_mon` first sampled high at cycle t → `rise_tick` high in cycle t+3 for exactly one cycle.
- `half_period`, `locked` and `fault` update in the same cycle as the corresponding tick.
- A timeout in LOCKED drops `locked` and raises `fault` in the cycle after `cnt` reaches NOM_HALF+TOL+1.
- No combinational path from any input to any output.

## Structure
- **Package `clock_monitor_pkg`:**
  - State enum: IDLE, ACQ, LOCKED, LOST.
  - Default constants for `NOM_HALF`, `TOL`, `LOCK_COUNT` and `CNT_W`.
  - Width of `gc`: clog2(LOCK_COUNT+1).
- **Sub-module `sync_edge_detect`:** the s1/s2/s3 flops plus the rise/fall pulse outputs. It is reused for other asynchronous inputs in the design.

## Test plan
- **Nominal lock:** reset, then toggle `clk_mon` every 100 cycles → `locked=1` on the 5th edge's tick; `half_period=100`; `fault=0`.
- **Out of tolerance:** toggle every 103 cycles → `locked` stays 0; `half_period=103`; `fault=0`.
- **Tolerance boundaries:** alternating half-periods of 98 and 102 → locks on the 5th edge.
- **Stall:**
  - Stimulus: lock, then hold `clk_mon` constant.
  - Required: `locked=0` and `fault=1` exactly 103 cycles after the last tick; `cnt` saturates at 255.
  - Stimulus: resume toggling at 100.
  - Required: relock after 1+4 edges; `fault` still 1.
- **fault_clr collision:** assert `fault_clr` in the same cycle as a LOCKED bad edge → `fault=1` afterwards. A lone `fault_clr` → `fault=0` next cycle.
- **Reset mid-lock:** assert `rst` for one cycle while locked → next cycle all outputs are 0 and state is IDLE; relock requires 5 edges.
